i2s_rx: RTL

- I2S master-mode receiver for the spectrometer microphone front end.
- Runs directly on the generated I2S bit clock, drives the word-select (WS) line, and deserialises the serial data line into signed PCM samples.
- Delivers samples over a valid/ready stream to the downstream windowing/FFT path.
- Flags overruns when the consumer stalls too long.

---
 rtl/i2s_pkg.sv | 11 +
 rtl/i2s_rx_slot_ctr.sv | 58 +++++
 rtl/i2s_rx.sv | 95 +++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared constants for the I2S master-mode receiver: default slot geometry
// and the channel encoding used on the word-select line and out_chan.
package i2s_pkg;

  localparam int I2S_SLOT_W = 32;
  localparam int I2S_DATA_W = 24;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_slot_ctr.sv
// Slot timing for the I2S receiver: bit counter, channel toggle, WS register
// and the capture-window decode (one-bit-delayed MSB-first data window).
module i2s_rx_slot_ctr
  import i2s_pkg::*;
#(
  parameter int SLOT_W = I2S_SLOT_W,
  parameter int DATA_W = I2S_DATA_W,
  localparam int CNT_W = $clog2(SLOT_W)
) (
  input  logic clk_in,
  input  logic reset,
  input  logic enable,
  output logic chan,
  output logic ws,
  output logic shift_en,
  output logic complete
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] DONE_BIT = CNT_W'(DATA_W);

  logic [CNT_W-1:0] bit_cnt;
  logic             wrap;
  logic             chan_nxt;

  assign wrap = (bit_cnt == LAST_BIT);

  always_comb begin
    chan_nxt = chan;
    if (!enable) begin
      chan_nxt = CH_LEFT;
    end else if (wrap) begin
      chan_nxt = (chan == CH_LEFT) ? CH_RIGHT : CH_LEFT;
    end
  end

  // ws is loaded with the same next value as chan so it changes exactly
  // on the cycle bit_cnt returns to 0.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      bit_cnt <= '0;
      chan    <= CH_LEFT;
      ws      <= CH_LEFT;
    end else begin
      chan <= chan_nxt;
      ws   <= chan_nxt;
      if (!enable || wrap) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign shift_en = enable && (bit_cnt != '0) && (bit_cnt <= DONE_BIT);
  assign complete = enable && (bit_cnt == DONE_BIT);

endmodule

// File: rtl/i2s_rx.sv
// I2S master-mode receiver: drives WS, deserialises SD into signed samples and
// presents them on a valid/ready stream. Define I2S_RX_STEREO_EN for both slots.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int SLOT_W = I2S_SLOT_W,
  parameter int DATA_W = I2S_DATA_W
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              enable,
  input  logic              i2s_sd,
  output logic              i2s_ws,
  output logic [DATA_W-1:0] out_data,
  output logic              out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  logic              chan;
  logic              shift_en;
  logic              complete;
  logic              take;
  logic              chan_cap;
  logic              accept;
  logic              lost;
  logic [DATA_W-1:0] sample;

  i2s_rx_slot_ctr #(
    .SLOT_W(SLOT_W),
    .DATA_W(DATA_W)
  ) u_slot_ctr (
    .clk_in  (clk_in),
    .reset   (reset),
    .enable  (enable),
    .chan    (chan),
    .ws      (i2s_ws),
    .shift_en(shift_en),
    .complete(complete)
  );

  // The sample is the held partial word plus the bit arriving this cycle,
  // so out_valid rises one clock after the last data bit.
  if (DATA_W > 1) begin : g_shift
    logic [DATA_W-2:0] shift;

    always_ff @(posedge clk_in) begin
      if (reset || !enable) begin
        shift <= '0;
      end else if (shift_en) begin
        shift <= sample[DATA_W-2:0];
      end
    end

    assign sample = {shift, i2s_sd};
  end else begin : g_no_shift
    assign sample = i2s_sd;
  end

`ifdef I2S_RX_STEREO_EN
  assign take     = complete;
  assign chan_cap = chan;
`else
  assign take     = complete && (chan == CH_LEFT);
  assign chan_cap = CH_LEFT;
`endif

  assign accept = out_valid && out_ready;
  assign lost   = take && out_valid && !out_ready;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      out_data  <= '0;
      out_chan  <= CH_LEFT;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (take) begin
        out_data  <= sample;
        out_chan  <= chan_cap;
        out_valid <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (lost) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
